// File: rtl/rtc_time_counter.sv
// rtc_time_counter
//
// Real-time clock core. Divides clk down to a 1 Hz tick and keeps a 24 h
// time of day in hour_rtc/min_rtc/sec_rtc. A user-interface FSM can load a
// new time with a one-cycle time_set strobe; out-of-range loads are refused
// and flagged on set_err.
//
// Parameters:
//   CLK_DIV      clk cycles per second (>= 2)
//   DIV_W        prescaler width, 2**DIV_W >= CLK_DIV
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset, overrides everything
//   run_en       1 = prescaler and time advance, 0 = both frozen
//   time_set     one-cycle load strobe
//   set_hour_in  hour to load (0..23)
//   set_min_in   minute to load (0..59)
//   set_sec_in   second to load (0..59)
//   hour_rtc     current hour (0..23)
//   min_rtc      current minute (0..59)
//   sec_rtc      current second (0..59)
//   sec_tick     one-cycle pulse, coincident with each new second value
//   day_wrap     one-cycle pulse, coincident with the 23:59:59 -> 00:00:00 step
//   set_err      sticky: the most recent time_set was rejected
//
// Optional build macro RTC_BCD_EN:
//   adds hour_bcd/min_bcd/sec_bcd (tens nibble high, units nibble low),
//   registered alongside the binary time and reset to 8'h00.

module rtc_time_counter #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned DIV_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       time_set,
  input  logic [4:0] set_hour_in,
  input  logic [5:0] set_min_in,
  input  logic [5:0] set_sec_in,
  output logic [4:0] hour_rtc,
  output logic [5:0] min_rtc,
  output logic [5:0] sec_rtc,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       set_err
`ifdef RTC_BCD_EN
  ,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
`endif
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);

  // Prescaler and time-of-day state
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;
  logic             set_err_q, set_err_d;

  logic tick;
  logic set_ok;

  // Terminal count only counts as a tick while running; a frozen prescaler
  // parked at DivLast must not keep firing.
  assign tick = run_en && (div_q == DivLast);

  assign set_ok = (set_hour_in <= 5'd23) &&
                  (set_min_in  <= 6'd59) &&
                  (set_sec_in  <= 6'd59);

  always_comb begin
    div_d      = div_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    set_err_d  = set_err_q;

    if (run_en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      sec_tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d     = 5'd0;
            day_wrap_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // A valid load wins over a coincident tick and restarts the second.
    // A rejected load only raises set_err; counting carries on untouched.
    if (time_set) begin
      if (set_ok) begin
        hour_d     = set_hour_in;
        min_d      = set_min_in;
        sec_d      = set_sec_in;
        div_d      = '0;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        set_err_d  = 1'b0;
      end else begin
        set_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      set_err_q  <= set_err_d;
    end
  end

  assign hour_rtc = hour_q;
  assign min_rtc  = min_q;
  assign sec_rtc  = sec_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign set_err  = set_err_q;

`ifdef RTC_BCD_EN
  // Binary 0..59 to packed two-digit BCD. A compare cascade is enough for
  // this range and avoids a divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    if (v >= 6'd50) begin
      tens = 4'd5; rem = v - 6'd50;
    end else if (v >= 6'd40) begin
      tens = 4'd4; rem = v - 6'd40;
    end else if (v >= 6'd30) begin
      tens = 4'd3; rem = v - 6'd30;
    end else if (v >= 6'd20) begin
      tens = 4'd2; rem = v - 6'd20;
    end else if (v >= 6'd10) begin
      tens = 4'd1; rem = v - 6'd10;
    end else begin
      tens = 4'd0; rem = v;
    end
    return {tens, rem[3:0]};
  endfunction

  logic [7:0] hour_bcd_q, min_bcd_q, sec_bcd_q;

  // Converted from the next-state values so BCD lands on the same edge as
  // the binary registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hour_bcd_q <= 8'h00;
      min_bcd_q  <= 8'h00;
      sec_bcd_q  <= 8'h00;
    end else begin
      hour_bcd_q <= to_bcd({1'b0, hour_d});
      min_bcd_q  <= to_bcd(min_d);
      sec_bcd_q  <= to_bcd(sec_d);
    end
  end

  assign hour_bcd = hour_bcd_q;
  assign min_bcd  = min_bcd_q;
  assign sec_bcd  = sec_bcd_q;
`endif

endmodule

// File: tb/tb_rtc_time_counter.sv
module tb_rtc_time_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic       time_set;
  logic [4:0] set_hour_in;
  logic [5:0] set_min_in;
  logic [5:0] set_sec_in;
  logic [4:0] hour_rtc;
  logic [5:0] min_rtc;
  logic [5:0] sec_rtc;
  logic       sec_tick;
  logic       day_wrap;
  logic       set_err;
`ifdef RTC_BCD_EN
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
`endif

  int total = 0;
  int bad   = 0;

  rtc_time_counter #(
    .CLK_DIV(4),
    .DIV_W  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .time_set   (time_set),
    .set_hour_in(set_hour_in),
    .set_min_in (set_min_in),
    .set_sec_in (set_sec_in),
    .hour_rtc   (hour_rtc),
    .min_rtc    (min_rtc),
    .sec_rtc    (sec_rtc),
    .sec_tick   (sec_tick),
    .day_wrap   (day_wrap),
    .set_err    (set_err)
`ifdef RTC_BCD_EN
    ,
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hour"}, 32'(hour_rtc), 32'(h));
    check({tag, ".min"},  32'(min_rtc),  32'(m));
    check({tag, ".sec"},  32'(sec_rtc),  32'(s));
  endtask

  task automatic load(input int h, input int m, input int s);
    time_set    = 1'b1;
    set_hour_in = 5'(h);
    set_min_in  = 6'(m);
    set_sec_in  = 6'(s);
    step(1);
    time_set    = 1'b0;
  endtask

  initial begin
    logic saw_tick;
    rst = 1'b1; run_en = 1'b1; time_set = 1'b0;
    set_hour_in = '0; set_min_in = '0; set_sec_in = '0;

    // 1. Reset then count
    step(3);
    check_time("rst", 0, 0, 0);
    check("rst.tick", 32'(sec_tick), 0);
    check("rst.wrap", 32'(day_wrap), 0);
    check("rst.err",  32'(set_err),  0);
    rst = 1'b0;
    step(3);
    check("pre_tick.sec", 32'(sec_rtc), 0);
    check("pre_tick.tick", 32'(sec_tick), 0);
    step(1);
    check("first_tick.sec", 32'(sec_rtc), 1);
    check("first_tick.tick", 32'(sec_tick), 1);
    step(1);
    check("tick_one_cycle", 32'(sec_tick), 0);
    step(15);
    check("twenty_edges.sec", 32'(sec_rtc), 5);

    // 2. Rollover through midnight
    load(23, 59, 58);
    check_time("set_2359", 23, 59, 58);
    check("set_2359.tick", 32'(sec_tick), 0);
    step(3);
    check("hold_58.sec", 32'(sec_rtc), 58);
    step(1);
    check_time("at_59", 23, 59, 59);
    check("at_59.wrap", 32'(day_wrap), 0);
    step(4);
    check_time("midnight", 0, 0, 0);
    check("midnight.wrap", 32'(day_wrap), 1);
    check("midnight.tick", 32'(sec_tick), 1);
    step(1);
    check("wrap_one_cycle", 32'(day_wrap), 0);

    // 3. Invalid set keeps counting; valid set recovers
    step(19);
    check_time("at_05", 0, 0, 5);
    load(24, 10, 0);
    check_time("bad_set", 0, 0, 5);
    check("bad_set.err", 32'(set_err), 1);
    step(3);
    check("bad_set.counts", 32'(sec_rtc), 6);
    check("bad_set.err_sticky", 32'(set_err), 1);
    load(1, 2, 3);
    check_time("good_set", 1, 2, 3);
    check("good_set.err", 32'(set_err), 0);
    // Invalid set on a terminal-count cycle must not block the tick
    step(3);
    load(5, 60, 0);
    check_time("bad_on_tc", 1, 2, 4);
    check("bad_on_tc.tick", 32'(sec_tick), 1);
    check("bad_on_tc.err", 32'(set_err), 1);

    // 4. Valid set colliding with a terminal count
    step(3);
    load(12, 0, 0);
    check_time("collide", 12, 0, 0);
    check("collide.tick", 32'(sec_tick), 0);
    check("collide.err", 32'(set_err), 0);
    step(3);
    check("collide.no_early", 32'(sec_rtc), 0);
    step(1);
    check("collide.next_sec", 32'(sec_rtc), 1);
    check("collide.next_tick", 32'(sec_tick), 1);

    // 5. Freeze mid-second, resume without losing the partial second
    step(2);
    run_en = 1'b0;
    saw_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sec_tick) saw_tick = 1'b1;
    end
    check("freeze.sec", 32'(sec_rtc), 1);
    check("freeze.no_tick", 32'(saw_tick), 0);
    run_en = 1'b1;
    step(1);
    check("resume.wait", 32'(sec_rtc), 1);
    step(1);
    check("resume.sec", 32'(sec_rtc), 2);
    check("resume.tick", 32'(sec_tick), 1);

    // 6. Mid-operation reset clears time and set_err
    load(10, 20, 30);
    check_time("pre_rst", 10, 20, 30);
    load(10, 20, 60);
    check("pre_rst.err", 32'(set_err), 1);
    rst = 1'b1;
    step(1);
    check_time("mid_rst", 0, 0, 0);
    check("mid_rst.err", 32'(set_err), 0);
    check("mid_rst.tick", 32'(sec_tick), 0);
`ifdef RTC_BCD_EN
    check("mid_rst.hbcd", 32'(hour_bcd), 32'h00);
    rst = 1'b0;
    load(23, 45, 9);
    check("bcd.hour", 32'(hour_bcd), 32'h23);
    check("bcd.min",  32'(min_bcd),  32'h45);
    check("bcd.sec",  32'(sec_bcd),  32'h09);
    step(4);
    check("bcd.tick_sec", 32'(sec_bcd), 32'h10);
`else
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
Name: rtc_time_counter

Overview:
Real-time clock core that produces the hour_rtc/min_rtc/sec_rtc time-of-day bus consumed by alarm_trigger_cond and the display path.
- Divides clk down to a 1 Hz tick.
- Counts seconds, minutes and hours in 24 h format.
- Accepts a validated time-set load from the user-interface FSM.

Parameters:
- CLK_DIV, 50000000, clk cycles per second (must be >= 2); bench uses 4.
- DIV_W, 26, prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- run_en  input  1  1 = clock runs; 0 = prescaler and time frozen
- time_set  input  1  one-cycle load strobe
- set_hour_in  input  5  hour to load, 0..23
- set_min_in  input  6  minute to load, 0..59
- set_sec_in  input  6  second to load, 0..59
- hour_rtc  output  5  current hour, 0..23
- min_rtc  output  6  current minute, 0..59
- sec_rtc  output  6  current second, 0..59
- sec_tick  output  1  one-cycle pulse on each second increment
- day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00
- set_err  output  1  sticky flag: last time_set was rejected

Behaviour:
- Reset (synchronous, active-high, on clk rising edge while rst=1): all outputs 0, prescaler 0. Reset overrides every other input.
- Prescaler: while run_en=1, counts 0..CLK_DIV-1 and wraps to 0. The terminal count (CLK_DIV-1) is the tick cycle. While run_en=0 it holds its value; no partial-second loss on resume.
- Tick cycle, registered, all updates take effect on the same edge:
  - sec_rtc increments; 59 -> 0 carries to min.
  - min 59 -> 0 carries to hour.
  - hour 23 -> 0 asserts day_wrap.
  - sec_tick=1 for exactly one cycle, coincident with the new sec_rtc value.
  - day_wrap=1 for exactly one cycle, coincident with the new 00:00:00.
- Tick rate: one tick every CLK_DIV cycles of run_en=1. With CLK_DIV=4, the first tick after reset lands on the 4th edge with run_en high.
- time_set:
  - Valid when hour<=23, min<=59, sec<=59.
  - Valid set: on the next edge, time registers load the inputs, prescaler clears to 0, set_err clears to 0. sec_tick and day_wrap stay 0 that cycle.
  - Invalid set: time and prescaler unaffected (counting continues normally); set_err goes to 1 and holds until the next valid set or reset.
  - Loads regardless of run_en.
- Simultaneous events: time_set has priority over a tick in the same cycle. The tick is discarded, the loaded value appears, and the next tick comes CLK_DIV run cycles later. An invalid set in a tick cycle does not block the tick.
- Outputs are always within range; no illegal state is reachable from reset.
- Latency: outputs change exactly one edge after the causing event (terminal count or time_set).

Optional Feature:
- Macro: RTC_BCD_EN.
- Defined: adds outputs hour_bcd[7:0], min_bcd[7:0], sec_bcd[7:0] (tens nibble high, units nibble low). They are registered, updated on the same edge as the binary outputs, and reset to 8'h00.
- Not defined: ports and logic absent; binary outputs unchanged.

Test Plan:
1. Reset then count: rst=1 for 3 cycles, run_en=1, CLK_DIV=4 -> outputs 0. sec_rtc=1 with sec_tick pulse after 4 edges; sec_rtc=5 after 20 edges.
2. Rollover: valid time_set 23:59:58, run 8 cycles -> 23:59:59, then 00:00:00 with day_wrap=1 for one cycle only.
3. Invalid set: time_set with hour=24, min=10, sec=0 while at 00:00:05 -> time keeps counting normally, set_err=1. A following valid set 01:02:03 -> loads, set_err=0.
4. Set/tick collision: time_set 12:00:00 on a terminal-count cycle -> 12:00:00 and no sec_tick; next sec_tick after exactly 4 cycles.
5. Freeze: run_en=0 for 10 cycles mid-second -> no change, no ticks. Resume -> tick after the remaining prescaler count, not a full 4.
6. Mid-operation reset: rst=1 at 10:20:30 -> all outputs and set_err 0 on the next edge. With RTC_BCD_EN, a 23:45:09 load shows 8'h23/8'h45/8'h09.
